mfsk_modulator: RTL and testbench

MFSK_MODULATOR -- requirements
Module: mfsk_modulator

---
 rtl/mfsk_pkg.sv | 30 +++
 rtl/mfsk_sine_lut.sv | 58 +++++
 rtl/mfsk_modulator.sv | 149 ++++++++++++++
 tb/tb_mfsk_modulator.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mfsk_pkg.sv
// Shared types and elaboration-time helpers for the MFSK modulator.
package mfsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam real PI = 3.14159265358979323846;

  // Phase increment for tone k; callers keep the low PHASE_W bits, which is
  // the modulo-2**PHASE_W wrap.
  function automatic logic [63:0] tone_inc(input logic [63:0] k,
                                           input logic [63:0] f_base,
                                           input logic [63:0] f_step);
    return f_base + k * f_step;
  endfunction

  // Rounded full-scale sine amplitude for one LUT address (half away from zero).
  function automatic int lut_amp(input int addr, input int lut_addr_w, input int out_w);
    real peak;
    real v;
    peak = (2.0 ** (out_w - 1)) - 1.0;
    v    = peak * $sin(2.0 * PI * real'(addr) / (2.0 ** lut_addr_w));
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(0.5 - v);
  endfunction

endpackage

// File: rtl/mfsk_sine_lut.sv
// Quarter-wave sine ROM with quadrant folding; two read ports, one register stage.
module mfsk_sine_lut
  import mfsk_pkg::*;
#(
  parameter int LUT_ADDR_W = 10,
  parameter int OUT_W      = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic [LUT_ADDR_W-1:0]   sin_addr_i,
  input  logic [LUT_ADDR_W-1:0]   cos_addr_i,
  output logic signed [OUT_W-1:0] sin_o,
  output logic signed [OUT_W-1:0] cos_o
);

  localparam int IDX_W = LUT_ADDR_W - 2;
  localparam int QTR   = 2 ** IDX_W;

  // Magnitudes for 0..pi/2 inclusive; the extra entry holds the peak so the
  // second quadrant can mirror without a special case.
  logic [OUT_W-2:0] rom [QTR+1];

  for (genvar g = 0; g <= QTR; g++) begin : g_rom
    assign rom[g] = (OUT_W-1)'(lut_amp(g, LUT_ADDR_W, OUT_W));
  end

  // Odd quadrants read the table backwards, upper half negates.
  function automatic logic signed [OUT_W-1:0] fold(input logic [LUT_ADDR_W-1:0] a);
    logic [IDX_W:0]          idx;
    logic [OUT_W-2:0]        mag;
    logic signed [OUT_W-1:0] pos;
    idx = {1'b0, a[IDX_W-1:0]};
    mag = a[IDX_W] ? rom[(IDX_W+1)'(QTR) - idx] : rom[idx];
    pos = signed'({1'b0, mag});
    return a[LUT_ADDR_W-1] ? -pos : pos;
  endfunction

  logic signed [OUT_W-1:0] sin_q, cos_q;

  // Output register: samples while enabled, forced to zero otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sin_q <= '0;
      cos_q <= '0;
    end else if (en_i) begin
      sin_q <= fold(sin_addr_i);
      cos_q <= fold(cos_addr_i);
    end else begin
      sin_q <= '0;
      cos_q <= '0;
    end
  end

  assign sin_o = sin_q;
  assign cos_o = cos_q;

endmodule

// File: rtl/mfsk_modulator.sv
// Phase-continuous MFSK modulator: alternating-tone preamble, then one tone
// per accepted symbol, quadrature sine/cosine output.
module mfsk_modulator
  import mfsk_pkg::*;
#(
  parameter int BITS_PER_SYM    = 3,
  parameter int PHASE_W         = 24,
  parameter int LUT_ADDR_W      = 10,
  parameter int OUT_W           = 18,
  parameter int SAMPLES_PER_SYM = 16,
  parameter int SYNC_SYMS       = 8,
  parameter int F_BASE          = 655,
  parameter int F_STEP          = 655
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BITS_PER_SYM-1:0] sym_data,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  output logic signed [OUT_W-1:0] sine_out,
  output logic signed [OUT_W-1:0] cos_out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    underrun
);

  localparam int M     = 2 ** BITS_PER_SYM;
  localparam int CNT_W = $clog2(SAMPLES_PER_SYM);
  localparam int PRE_W = $clog2(SYNC_SYMS + 1);
  localparam int QTR   = 2 ** (LUT_ADDR_W - 2);
  localparam logic [BITS_PER_SYM-1:0] TONE_LO = '0;
  localparam logic [BITS_PER_SYM-1:0] TONE_HI = BITS_PER_SYM'(M - 1);

  function automatic logic [PHASE_W-1:0] inc_of(input logic [BITS_PER_SYM-1:0] k);
    return PHASE_W'(tone_inc(64'(k), 64'(F_BASE), 64'(F_STEP)));
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] inc_q, inc_d;
  logic               underrun_q, underrun_d;
  logic               out_valid_q;

  logic last_cyc, last_pre, xfer;

  assign last_cyc = (cnt_q == CNT_W'(SAMPLES_PER_SYM - 1));
  assign last_pre = (pre_q == PRE_W'(SYNC_SYMS - 1));
  assign xfer     = sym_valid & sym_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: symbol boundaries either continue with new data or stop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_SYNC;
      ST_SYNC: if (last_cyc && last_pre) state_d = sym_valid ? ST_DATA : ST_IDLE;
      ST_DATA: if (last_cyc) state_d = sym_valid ? ST_DATA : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: ready only on the final sample of the last preamble symbol
  // and of every data symbol.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    sym_ready = 1'b0;
    if (last_cyc && ((state_q == ST_SYNC && last_pre) || state_q == ST_DATA))
      sym_ready = 1'b1;
  end

  // Datapath next state: the accumulator runs freely across symbol
  // boundaries; only a new burst clears it.
  always_comb begin
    cnt_d      = cnt_q;
    pre_d      = pre_q;
    acc_d      = acc_q;
    inc_d      = inc_q;
    underrun_d = sym_ready & ~sym_valid;
    if (state_q == ST_IDLE) begin
      if (start) begin
        cnt_d = '0;
        pre_d = '0;
        acc_d = '0;
        inc_d = inc_of(TONE_LO);
      end
    end else begin
      acc_d = acc_q + inc_q;
      cnt_d = last_cyc ? '0 : cnt_q + 1'b1;
      if (last_cyc) begin
        if (state_q == ST_SYNC && !last_pre) begin
          pre_d = pre_q + 1'b1;
          inc_d = inc_of(pre_q[0] ? TONE_LO : TONE_HI);
        end else if (xfer) begin
          inc_d = inc_of(sym_data);
        end
      end
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      pre_q       <= '0;
      acc_q       <= '0;
      inc_q       <= '0;
      underrun_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pre_q       <= pre_d;
      acc_q       <= acc_d;
      inc_q       <= inc_d;
      underrun_q  <= underrun_d;
      out_valid_q <= busy;
    end
  end

  logic [LUT_ADDR_W-1:0] sin_addr, cos_addr;

  assign sin_addr = acc_q[PHASE_W-1 -: LUT_ADDR_W];
  assign cos_addr = sin_addr + LUT_ADDR_W'(QTR);

  // Sample stage: one register after the accumulator, aligned with out_valid.
  mfsk_sine_lut #(
    .LUT_ADDR_W (LUT_ADDR_W),
    .OUT_W      (OUT_W)
  ) u_lut (
    .clk        (clk),
    .reset      (reset),
    .en_i       (busy),
    .sin_addr_i (sin_addr),
    .cos_addr_i (cos_addr),
    .sin_o      (sine_out),
    .cos_o      (cos_out)
  );

  assign out_valid = out_valid_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_mfsk_modulator.sv
// Scoreboard bench for mfsk_modulator with a tone-sequence reference model.
module tb_mfsk_modulator;

  localparam int BPS = 3, PW = 16, LAW = 10, OW = 18, SPS = 16, SS = 8;
  localparam int FB = 655, FS = 655;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, sym_valid, sym_ready, out_valid, busy, underrun;
  logic [BPS-1:0] sym_data;
  logic signed [OW-1:0] sine_out, cos_out;

  logic start1, sym_valid1, sym_ready1, out_valid1, busy1, underrun1;
  logic [0:0] sym_data1;
  logic signed [OW-1:0] sine1, cos1;

  mfsk_modulator #(.BITS_PER_SYM(BPS), .PHASE_W(PW), .LUT_ADDR_W(LAW), .OUT_W(OW),
                   .SAMPLES_PER_SYM(SPS), .SYNC_SYMS(SS), .F_BASE(FB), .F_STEP(FS)) dut (
    .clk(clk), .reset(reset), .start(start), .sym_data(sym_data), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .sine_out(sine_out), .cos_out(cos_out), .out_valid(out_valid),
    .busy(busy), .underrun(underrun));

  mfsk_modulator #(.BITS_PER_SYM(1), .PHASE_W(PW), .LUT_ADDR_W(LAW), .OUT_W(OW),
                   .SAMPLES_PER_SYM(SPS), .SYNC_SYMS(SS), .F_BASE(FB), .F_STEP(FS)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .sym_data(sym_data1), .sym_valid(sym_valid1),
    .sym_ready(sym_ready1), .sine_out(sine1), .cos_out(cos1), .out_valid(out_valid1),
    .busy(busy1), .underrun(underrun1));

  typedef struct packed { int s; int c; } samp_t;
  samp_t exp_q[$];
  samp_t exp1_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int amp(input int a);
    real v;
    v = ((2.0 ** (OW - 1)) - 1.0) * $sin(2.0 * 3.14159265358979323846 * real'(a) / (2.0 ** LAW));
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(0.5 - v);
  endfunction

  function automatic int inc_of(input int k);
    return (FB + k * FS) % (1 << PW);
  endfunction

  // Expected samples of a burst: preamble tones then data tones, phase never reset.
  task automatic predict(input int m, input int syms[$], input bit to1);
    int tones[$];
    int acc;
    int addr;
    samp_t e;
    acc = 0;
    for (int j = 0; j < SS; j++) tones.push_back((j % 2 == 1) ? m - 1 : 0);
    foreach (syms[i]) tones.push_back(syms[i]);
    for (int n = 0; n < tones.size() * SPS; n++) begin
      addr = acc >> (PW - LAW);
      e.s  = amp(addr);
      e.c  = amp((addr + (1 << (LAW - 2))) % (1 << LAW));
      if (to1) exp1_q.push_back(e);
      else     exp_q.push_back(e);
      acc = (acc + inc_of(tones[n / SPS])) % (1 << PW);
    end
  endtask

  // Monitors: pop one expected sample per valid output.
  always @(negedge clk) begin
    samp_t e;
    if (out_valid) begin
      if (exp_q.size() == 0) check("unexpected_sample", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("sine_out", sine_out, e.s);
        check("cos_out", cos_out, e.c);
      end
    end else begin
      check("idle_sine_zero", sine_out, 0);
      check("idle_cos_zero", cos_out, 0);
    end
  end

  always @(negedge clk) begin
    samp_t e;
    if (out_valid1) begin
      if (exp1_q.size() == 0) check("b1_unexpected_sample", 1, 0);
      else begin
        e = exp1_q.pop_front();
        check("b1_sine_out", sine1, e.s);
        check("b1_cos_out", cos1, e.c);
      end
    end
  end

  // Called at a falling edge; start is sampled at the next rising edge.
  task automatic run_burst(input int syms[$], input int abort_at, input bit with1);
    int  total;
    int  didx;
    bit  exp_rdy;
    predict(1 << BPS, syms, 1'b0);
    total = (SS + syms.size()) * SPS;
    start = 1'b1;
    sym_valid = 1'b0;
    if (with1) start1 = 1'b1;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (c == abort_at) begin
        #2 reset = 1'b1;
        start = 1'b0;
        sym_valid = 1'b0;
        #1;
        check("abort_sine", sine_out, 0);
        check("abort_cos", cos_out, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_sym_ready", sym_ready, 0);
        exp_q.delete();
        return;
      end
      check("busy", busy, 1);
      exp_rdy = (c % SPS == SPS - 1) && (c / SPS >= SS - 1);
      check("sym_ready", sym_ready, longint'(exp_rdy));
      start = ($urandom_range(0, 7) == 0);
      if (exp_rdy) begin
        didx = c / SPS - (SS - 1);
        if (didx < syms.size()) begin
          sym_valid = 1'b1;
          sym_data  = BPS'(syms[didx]);
        end else begin
          sym_valid = 1'b0;
          sym_data  = BPS'($urandom_range(0, (1 << BPS) - 1));
        end
      end else begin
        sym_valid = 1'($urandom_range(0, 1));
        sym_data  = BPS'($urandom_range(0, (1 << BPS) - 1));
      end
    end
    @(negedge clk);
    start = 1'b0;
    sym_valid = 1'b0;
    check("busy_after_end", busy, 0);
    check("underrun_pulse", underrun, 1);
    check("sym_ready_idle", sym_ready, 0);
    @(negedge clk);
    check("underrun_single", underrun, 0);
    check("out_valid_idle", out_valid, 0);
    check("all_samples_seen", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int syms[$];
    int none[$];
    int n;
    reset = 1'b1; start = 1'b0; sym_valid = 1'b0; sym_data = '0;
    start1 = 1'b0; sym_valid1 = 1'b0; sym_data1 = '0;
    repeat (3) @(negedge clk);
    check("rst_sine", sine_out, 0);
    check("rst_cos", cos_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sym_ready", sym_ready, 0);
    check("rst_underrun", underrun, 0);

    // Start on the very first edge after reset; symbol 3 first, then 0..7.
    reset = 1'b0;
    syms = '{3, 0, 1, 2, 3, 4, 5, 6, 7};
    predict(2, none, 1'b1);
    run_burst(syms, -1, 1'b1);
    check("b1_samples_seen", exp1_q.size(), 0);
    check("b1_busy_idle", busy1, 0);

    // Random bursts, including a preamble-only burst when n is 0.
    for (int b = 0; b < 4; b++) begin
      syms.delete();
      n = (b == 0) ? 0 : $urandom_range(1, 10);
      repeat (n) syms.push_back($urandom_range(0, (1 << BPS) - 1));
      @(negedge clk);
      run_burst(syms, -1, 1'b0);
    end

    // Reset in the middle of data symbol 5, then a fresh full burst.
    syms.delete();
    repeat (8) syms.push_back($urandom_range(0, (1 << BPS) - 1));
    @(negedge clk);
    run_burst(syms, (SS + 5) * SPS + 7, 1'b0);
    @(negedge clk);
    check("in_reset_busy", busy, 0);
    check("in_reset_out_valid", out_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    syms.delete();
    repeat (3) syms.push_back($urandom_range(0, (1 << BPS) - 1));
    run_burst(syms, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
